// File: rtl/uart_receive_fsm.sv
// uart_receive_fsm: oversampling UART receiver, 8E1-style frames.
// Optional saturating error counter: define UART_RX_ERR_CNT_EN.
module uart_receive_fsm #(
  parameter int DATA_LEN   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                rx_idle,
  output logic [7:0]          err_count
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_LEN + 1);

  localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(DATA_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic [DATA_LEN:0]   shift_in;
  logic                p_bad_q, p_bad_d;
  logic                stop_q, stop_d;
  logic                commit_q, commit_d;
  logic                rx_m, rx_s;
  logic                take;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      p_bad_q  <= 1'b0;
      stop_q   <= 1'b1;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      p_bad_q  <= p_bad_d;
      stop_q   <= stop_d;
      commit_q <= commit_d;
    end
  end

  assign shift_in = {rx_s, shift_q};

  // Next-state logic: half-bit to the start centre, then one bit per period.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    p_bad_d  = p_bad_q;
    stop_d   = stop_q;
    commit_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_END) begin
          cnt_d   = '0;
          shift_d = shift_in[DATA_LEN:1];
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_END) begin
            state_d = PARITY;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == FULL_END) begin
          cnt_d   = '0;
          p_bad_d = rx_s ^ (^shift_q);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_END) begin
          cnt_d    = '0;
          stop_d   = rx_s;
          commit_d = 1'b1;
          state_d  = rx_s ? IDLE : BREAK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame may enter the buffer when it is empty or draining this cycle.
  assign take = !rx_valid || rx_ready;

  // One-entry output buffer with sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_q) begin
      if (take) begin
        rx_data    <= shift_q;
        rx_valid   <= 1'b1;
        parity_err <= p_bad_q;
        frame_err  <= ~stop_q;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign rx_idle = (state_q == IDLE) && !rx_valid && !commit_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_q;
  logic       err_hit;

  assign err_hit = commit_q && (p_bad_q || !stop_q || !take);

  // Saturating per-frame error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (err_hit && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule
